// File: rtl/bit_paketleyici.sv
// Variable-length MSB-first bit writer: packs codes into 32-bit words over valid/ready.
// Define PAD_ONES_EN to pad the final flushed word with 1s instead of 0s.
module bit_paketleyici #(
  parameter int MAX_LEN = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MAX_LEN-1:0] veri_i,
  input  logic [5:0]         uzunluk_i,
  input  logic               gecerli_i,
  output logic               hazir_o,
  input  logic               flush_i,
  output logic [31:0]        kelime_o,
  output logic               kelime_gecerli_o,
  input  logic               kelime_hazir_i,
  output logic               bitti_o
);

  typedef enum logic [1:0] {
    CALIS  = 2'd0,
    BOSALT = 2'd1,
    BITTI  = 2'd2
  } durum_e;

  localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);
`ifdef PAD_ONES_EN
  localparam logic [31:0] DOLGU_TABAN = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] DOLGU_TABAN = 32'h0000_0000;
`endif

  durum_e      durum_q, durum_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  doluluk_q, doluluk_d;
  logic [31:0] kelime_q, kelime_d;
  logic        kelime_gecerli_q, kelime_gecerli_d;
  logic        bitti_q, bitti_d;

  logic [5:0]  boy_s;
  logic [63:0] kod_s;
  logic [6:0]  kayma_s;
  logic [31:0] dolgu_s;
  logic        kabul_s;
  logic        cikis_bos_s;
  logic        tam_kelime_s;

  assign hazir_o          = rst_i && (durum_q == CALIS) && (doluluk_q < 6'd32);
  assign kabul_s          = gecerli_i && hazir_o;
  assign cikis_bos_s      = !kelime_gecerli_q || kelime_hazir_i;
  assign tam_kelime_s     = (doluluk_q >= 6'd32);
  assign kelime_o         = kelime_q;
  assign kelime_gecerli_o = kelime_gecerli_q;
  assign bitti_o          = bitti_q;

  // Saturate the length, mask the code and find where it lands in the accumulator
  always_comb begin
    if (uzunluk_i > MAX_LEN_W) begin
      boy_s = MAX_LEN_W;
    end else begin
      boy_s = uzunluk_i;
    end
    kod_s   = {{(64-MAX_LEN){1'b0}}, veri_i} & ((64'd1 << boy_s) - 64'd1);
    kayma_s = 7'd64 - {1'b0, doluluk_q} - {1'b0, boy_s};
    dolgu_s = DOLGU_TABAN >> doluluk_q;
  end

  // Next-state, accumulator and output-word logic
  always_comb begin
    durum_d   = durum_q;
    acc_d     = acc_q;
    doluluk_d = doluluk_q;
    kelime_d  = kelime_q;
    if (kelime_gecerli_q && kelime_hazir_i) begin
      kelime_gecerli_d = 1'b0;
    end else begin
      kelime_gecerli_d = kelime_gecerli_q;
    end

    case (durum_q)
      CALIS: begin
        if (tam_kelime_s && cikis_bos_s) begin
          kelime_d         = acc_q[63:32];
          kelime_gecerli_d = 1'b1;
          acc_d            = {acc_q[31:0], 32'h0000_0000};
          doluluk_d        = doluluk_q - 6'd32;
        end else if (kabul_s && (boy_s != 6'd0)) begin
          acc_d     = acc_q | (kod_s << kayma_s);
          doluluk_d = doluluk_q + boy_s;
        end else begin
          acc_d = acc_q;
        end
        // A symbol accepted alongside the flush request is already in acc_d
        if (flush_i) begin
          durum_d = BOSALT;
        end else begin
          durum_d = CALIS;
        end
      end
      BOSALT: begin
        if (tam_kelime_s && cikis_bos_s) begin
          kelime_d         = acc_q[63:32];
          kelime_gecerli_d = 1'b1;
          acc_d            = {acc_q[31:0], 32'h0000_0000};
          doluluk_d        = doluluk_q - 6'd32;
        end else if (!tam_kelime_s && (doluluk_q != 6'd0) && cikis_bos_s) begin
          kelime_d         = acc_q[63:32] | dolgu_s;
          kelime_gecerli_d = 1'b1;
          acc_d            = 64'h0;
          doluluk_d        = 6'd0;
        end else if ((doluluk_q == 6'd0) && cikis_bos_s) begin
          durum_d = BITTI;
        end else begin
          durum_d = BOSALT;
        end
      end
      BITTI: begin
        acc_d     = 64'h0;
        doluluk_d = 6'd0;
        durum_d   = CALIS;
      end
      default: begin
        acc_d     = 64'h0;
        doluluk_d = 6'd0;
        durum_d   = CALIS;
      end
    endcase

    bitti_d = (durum_d == BITTI);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q          <= CALIS;
      acc_q            <= 64'h0;
      doluluk_q        <= 6'd0;
      kelime_q         <= 32'h0000_0000;
      kelime_gecerli_q <= 1'b0;
      bitti_q          <= 1'b0;
    end else begin
      durum_q          <= durum_d;
      acc_q            <= acc_d;
      doluluk_q        <= doluluk_d;
      kelime_q         <= kelime_d;
      kelime_gecerli_q <= kelime_gecerli_d;
      bitti_q          <= bitti_d;
    end
  end

endmodule

// File: doc/bit_paketleyici.md
# bit_paketleyici

- Variable-length bit writer for the entropy-coding path.
- Accepts one code per handshake: value plus length 1..MAX_LEN. Codes are packed MSB-first into a contiguous bitstream and emitted as 32-bit words over a valid/ready output.
- It is the encoder-side counterpart of the left-rotate bit extractor used by the DC/AC decoders: the word emitted here is the word that side consumes from its top bits down.

## Interface
- `MAX_LEN`, default 16: maximum code length per symbol; legal range 1..32.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset; one clock, synchronous, active-low.
- `veri_i`  in  MAX_LEN  code value, right-aligned; bits at and above `uzunluk_i` ignored.
- `uzunluk_i`  in  6  code length; 0 = no-op; values > MAX_LEN saturate to MAX_LEN.
- `gecerli_i`  in  1  input symbol valid.
- `hazir_o`  out  1  ready for a symbol; a transfer occurs when `gecerli_i && hazir_o`.
- `flush_i`  in  1  single-cycle request: drain all buffered bits, padding the last word.
- `kelime_o`  out  32  packed output word; first-written bit in bit 31.
- `kelime_gecerli_o`  out  1  output word valid.
- `kelime_hazir_i`  in  1  downstream ready.
- `bitti_o`  out  1  one-cycle pulse when a flush has completed.

## Operation

**Storage**
- 64-bit accumulator `acc`, MSB-aligned.
- Fill count `doluluk` 0..63.
- Output word register.

**Symbol accept**
- Masked code is placed at `acc[63-doluluk -: uzunluk]`.
- Update: `doluluk += uzunluk`.
- `hazir_o = (state==CALIS) && (doluluk<32)`. Because of this and `uzunluk` ≤ 32, `doluluk` never exceeds 63.

**Word emit**
- Condition: `doluluk>=32` and the output register is free (`!kelime_gecerli_o || kelime_hazir_i`).
- Action: `acc[63:32]` loads into `kelime_o` and `kelime_gecerli_o` is set. `acc` shifts left 32 and `doluluk -= 32`.
- Accept and emit are mutually exclusive in a cycle because of the `doluluk` bounds.

**Output handshake**
- `kelime_o` is held stable while `kelime_gecerli_o=1 && kelime_hazir_i=0`.
- `kelime_gecerli_o` clears on transfer unless a new word loads in the same cycle.

**FSM**
- CALIS
  - Normal packing.
  - `flush_i=1` moves to BOSALT. A symbol accepted in the same cycle is included in the flush.
  - `flush_i` is ignored outside CALIS.
- BOSALT
  - `hazir_o=0`.
  - Emit full words while `doluluk>=32`.
  - When `1<=doluluk<=31` and the output register is free: pad bits `[63-doluluk:32]`, emit, set `doluluk=0`.
  - When `doluluk==0` and the output register is empty or transferring: go to BITTI.
- BITTI
  - `bitti_o=1` for one cycle.
  - Accumulator cleared; return to CALIS.

**Reset** (`rst_i` low at an edge):
- State returns to CALIS; `acc` and `doluluk` cleared.
- Any pending output word is dropped.
- Applies mid-packing or mid-flush; no `bitti_o` pulse results.

## Timing

**Reset values**
- `kelime_o` = 0, `kelime_gecerli_o` = 0, `bitti_o` = 0.
- `hazir_o` = 0 while `rst_i` is low; `hazir_o` = 1 in the first cycle after release.

**Latency**
- The symbol that brings `doluluk` to ≥32 is accepted at edge N.
- `kelime_gecerli_o` rises after edge N+1, provided the output register is free.

**Throughput**
- One symbol per cycle while `doluluk<32`.
- Each word emit costs one stall cycle on `hazir_o`.

**Flush**
- With `doluluk` = 0 and the output register empty: `flush_i` at edge N gives `bitti_o` high after edge N+1.
- Otherwise: one cycle per word emitted plus output back-pressure, then one more cycle to BITTI.

**Back-pressure**
- With the output register full and `doluluk>=32`, `hazir_o` stays 0 indefinitely.
- No bit is lost or reordered.

## Configuration
- `PAD_ONES_EN` defined: flush padding bits are 1 (JPEG byte-fill convention).
- Undefined: padding bits are 0.
- No other behaviour differs.

## Test plan
1. **Reset:** hold `rst_i` low 3 cycles with `gecerli_i=1` → all outputs 0 throughout; `hazir_o=1` in the first cycle after release; no word emitted.
2. **Aligned packing:** eight 4-bit symbols 0x1..0x8 back-to-back, `kelime_hazir_i=1` → exactly one word 0x12345678, with `hazir_o` low one cycle after the 8th symbol. Then `flush_i` → no further word; `bitti_o` pulses 2 edges after flush.
3. **Straddle and pad:** symbols (12, 0xABC), (16, 0xDE12), (8, 0x34), then `flush_i` → words 0xABCDE123 then 0x4FFFFFFF with `PAD_ONES_EN`, or 0x40000000 without; then `bitti_o`.
4. **Masking and saturation:** `veri_i=0xFFFF`, `uzunluk_i=4`, eight times → 0xFFFFFFFF. `uzunluk_i=40` with `veri_i=0x0001` is accepted as 16 bits, value 0x0001. `uzunluk_i=0` leaves `doluluk` unchanged.
5. **Back-pressure:** `kelime_hazir_i=0` for 10 cycles while feeding 16-bit symbols 0x0001..0x0005 → `kelime_o` holds 0x00010002 stable and `hazir_o` drops. After release, words are 0x00010002 then 0x00030004 in order, no loss. Flush then yields 0x0005FFFF with `PAD_ONES_EN`, or 0x00050000 without.
6. **Reset mid-flush:** 20 bits buffered, `flush_i`, then `rst_i` low for 1 cycle before the padded word transfers → `kelime_gecerli_o=0` and no `bitti_o` pulse. The next 32 bits fed produce a word with no residue from before reset.
